frac_ce_bank: RTL



---
 rtl/frac_ce_bank.sv | 138 +++++++++++++
 1 files changed

// File: rtl/frac_ce_bank.sv
// frac_ce_bank: bank of NUM_CH phase-accumulator NCOs. Each one produces a
// fractional-rate, one-cycle clock-enable pulse train on the fast clock.
// A configuration write lands in a per-channel shadow register. A write with
// cfg_commit=1 copies every shadow to live in one cycle, so the relative
// phase between channels is exact. The bank then settles and reports locked.
//
// Ports
//   clk        fast clock; all logic runs on its rising edge
//   reset_n    asynchronous active-low reset
//   cfg_valid  configuration write request
//   cfg_ready  write accepted when cfg_valid && cfg_ready (IDLE / LOCKED only)
//   cfg_ch     target channel; values >= NUM_CH drop the data
//   cfg_inc    increment; ce rate = f_clk * inc / 2^ACC_W
//   cfg_phase  accumulator preset, loaded at commit
//   cfg_commit 1 = apply all shadows to live and relock
//   ce         one-cycle enable pulse per channel, gated off unless locked
//   locked     live configuration applied and settled
//
// state  | meaning
// IDLE   | after reset, nothing committed yet, writes accepted
// APPLY  | one cycle: shadows copied to live, accumulators preset
// SETTLE | LOCK_CYCLES cycles with accumulators running and ce gated off
// LOCKED | ce outputs live, writes accepted
module frac_ce_bank #(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              cfg_commit,
  output logic [NUM_CH-1:0] ce,
  output logic              locked
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SETTLE, S_LOCKED} state_t;

  // The settle counter only has to hold LOCK_CYCLES-1.
  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;

  logic [ACC_W-1:0]  shadow_inc_q   [NUM_CH];
  logic [ACC_W-1:0]  shadow_phase_q [NUM_CH];
  logic [ACC_W-1:0]  live_inc_q     [NUM_CH];
  logic [ACC_W-1:0]  acc_q          [NUM_CH];
  logic [ACC_W:0]    sum            [NUM_CH];
  logic [NUM_CH-1:0] ce_q;

  assign cfg_ready = (state_q == S_IDLE) || (state_q == S_LOCKED);
  assign accept    = cfg_valid && cfg_ready;
  assign locked    = (state_q == S_LOCKED);
  // The accumulators keep running while settling, so only the outputs are gated.
  assign ce        = ce_q & {NUM_CH{locked}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_LOCKED: if (accept && cfg_commit) state_d = S_APPLY;
      S_APPLY: begin
        state_d = S_SETTLE;
        cnt_d   = CNT_W'(LOCK_CYCLES - 1);
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_LOCKED;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The shadow write happens on the accept edge. APPLY follows one cycle
  // later, so a committing write's own data is included in that commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_inc_q[i]   <= '0;
        shadow_phase_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept && (cfg_ch == CH_W'(i))) begin
          shadow_inc_q[i]   <= cfg_inc;
          shadow_phase_q[i] <= cfg_phase;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc_q[i]} + {1'b0, live_inc_q[i]};
    end
  end

  // The carry out of the add becomes next cycle's pulse. This gives an exact
  // average rate of inc / 2^ACC_W with no drift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        live_inc_q[i] <= '0;
        acc_q[i]      <= '0;
      end
      ce_q <= '0;
    end else if (state_q == S_APPLY) begin
      for (int i = 0; i < NUM_CH; i++) begin
        live_inc_q[i] <= shadow_inc_q[i];
        acc_q[i]      <= shadow_phase_q[i];
      end
      ce_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= sum[i][ACC_W-1:0];
        ce_q[i]  <= sum[i][ACC_W];
      end
    end
  end

endmodule
